// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a time-multiplexed FIR datapath.
// Writes each accepted sample into a circular delay line, then walks all taps
// issuing one coefficient/sample read pair per cycle, drives the accumulator
// clear/enable strobes and flags the finished result once the MAC pipe drains.
// Coefficient writes are only let through while no convolution is in flight.
module fir_tap_sequencer #(
  parameter int unsigned AW      = 11,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned CW      = 20
) (
  input  logic          clk_fast,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [DW-1:0] din,
  input  logic          CLOAD,
  input  logic [AW-1:0] CADDR,
  input  logic [CW-1:0] CIN,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [DW-1:0] smp_wdata,
  output logic          coef_we,
  output logic [AW-1:0] coef_waddr,
  output logic [CW-1:0] coef_wdata,
  output logic          rd_en,
  output logic [AW-1:0] coef_raddr,
  output logic [AW-1:0] smp_raddr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_strobe,
  output logic          busy,
  output logic          overrun,
  output logic          cload_err
);

  localparam int unsigned DrainW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(MAC_LAT - 1);
  localparam logic [AW-1:0] KLast = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     k_q, k_d;
  logic [DrainW-1:0] drain_q, drain_d;

  logic busy_q, busy_d;
  logic out_strobe_q, out_strobe_d;
  logic overrun_q, overrun_d;
  logic cload_err_q, cload_err_d;

  // Delay lines aligning read strobes with products arriving at the accumulator
  logic [MAC_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [MAC_LAT-1:0] clr_pipe_q, clr_pipe_d;

  logic in_flight;
  logic rd_active;
  logic first_tap;

  assign in_flight = (state_q != StIdle);
  assign rd_active = (state_q == StRun);
  assign first_tap = rd_active && (k_q == '0);

  // Next-state logic for the tap walk and drain countdown
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (valid_in) begin
          base_d  = wptr_q;
          wptr_d  = wptr_q + AW'(1);
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (k_q == KLast) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered status outputs and sticky error flags
  always_comb begin
    busy_d       = (state_d != StIdle);
    out_strobe_d = (state_d == StDone);
    overrun_d    = overrun_q | (valid_in & in_flight);
    cload_err_d  = cload_err_q | (CLOAD & in_flight);
    en_pipe_d    = MAC_LAT'({en_pipe_q, rd_active});
    clr_pipe_d   = MAC_LAT'({clr_pipe_q, first_tap});
  end

  // All sequencer state; synchronous reset aborts any sequence in progress
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      base_q       <= '0;
      k_q          <= '0;
      drain_q      <= '0;
      busy_q       <= 1'b0;
      out_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
      cload_err_q  <= 1'b0;
      en_pipe_q    <= '0;
      clr_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      base_q       <= base_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      out_strobe_q <= out_strobe_d;
      overrun_q    <= overrun_d;
      cload_err_q  <= cload_err_d;
      en_pipe_q    <= en_pipe_d;
      clr_pipe_q   <= clr_pipe_d;
    end
  end

  // RAM write/read ports; write strobes are masked during reset so nothing
  // reaches the RAMs while the sequencer is being cleared
  always_comb begin
    smp_we     = 1'b0;
    smp_waddr  = '0;
    smp_wdata  = '0;
    coef_we    = 1'b0;
    coef_waddr = '0;
    coef_wdata = '0;
    rd_en      = 1'b0;
    coef_raddr = '0;
    smp_raddr  = '0;
    if (!reset && !in_flight) begin
      if (valid_in) begin
        smp_we    = 1'b1;
        smp_waddr = wptr_q;
        smp_wdata = din;
      end
      if (CLOAD) begin
        coef_we    = 1'b1;
        coef_waddr = CADDR;
        coef_wdata = CIN;
      end
    end
    if (rd_active) begin
      rd_en      = 1'b1;
      coef_raddr = k_q;
      // Newest sample pairs with tap 0; older samples sit at lower addresses
      smp_raddr  = base_q - k_q;
    end
  end

  assign acc_en     = en_pipe_q[MAC_LAT-1];
  assign acc_clr    = clr_pipe_q[MAC_LAT-1];
  assign out_strobe = out_strobe_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign cload_err  = cload_err_q;

endmodule
